// File: rtl/spi_master.sv
// Mode-0 SPI master: one 1..16 bit MSB-first transfer per request, received
// bits returned right-aligned on a valid/ready response port.
module spi_master #(
  parameter int DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_data,
  input  logic [4:0]  req_len,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        sck,
  output logic        ss,
  output logic        mosi,
  input  logic        miso
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] div_cnt;
  logic [4:0]    len_r;
  logic [4:0]    bit_cnt;
  logic [15:0]   tx_sr;
  logic [15:0]   rx_sr;
  logic [4:0]    eff_len;
  logic [15:0]   tx_load;
  logic          phase_end;

  // Transmit data is left-justified so the next bit to send is always tx_sr[15].
  always_comb begin
    eff_len   = ((req_len == 5'd0) || (req_len > 5'd16)) ? 5'd16 : req_len;
    tx_load   = req_data << (5'd16 - eff_len);
    phase_end = (div_cnt == DIV_LAST);
  end

  assign req_ready = (state == S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      sck        <= 1'b0;
      ss         <= 1'b1;
      mosi       <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= 16'h0000;
      bit_cnt    <= 5'd0;
      div_cnt    <= '0;
      len_r      <= 5'd0;
      tx_sr      <= 16'h0000;
      rx_sr      <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            state   <= S_SETUP;
            ss      <= 1'b0;
            sck     <= 1'b0;
            len_r   <= eff_len;
            tx_sr   <= tx_load;
            mosi    <= tx_load[15];
            rx_sr   <= 16'h0000;
            bit_cnt <= 5'd0;
            div_cnt <= '0;
          end
        end
        S_SETUP: begin
          if (phase_end) begin
            state   <= S_HIGH;
            sck     <= 1'b1;
            rx_sr   <= {rx_sr[14:0], miso};
            bit_cnt <= bit_cnt + 5'd1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            state   <= S_LOW;
            sck     <= 1'b0;
            div_cnt <= '0;
            // After the final bit mosi is left holding its last value.
            if (bit_cnt != len_r) begin
              tx_sr <= tx_sr << 1;
              mosi  <= tx_sr[14];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_LOW: begin
          if (phase_end) begin
            div_cnt <= '0;
            if (bit_cnt == len_r) begin
              state      <= S_DONE;
              ss         <= 1'b1;
              resp_valid <= 1'b1;
              resp_data  <= rx_sr;
            end else begin
              state   <= S_HIGH;
              sck     <= 1'b1;
              rx_sr   <= {rx_sr[14:0], miso};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: table vectors, randomized transfers against an
// arithmetic slave model, reset/backpressure sequences and a DIV=1 build.
module tb_spi_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_data = 16'h0000;
  logic [4:0]  req_len = 5'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_data;
  logic        sck, ss, mosi, miso;

  logic        d1_req_valid = 1'b0;
  logic        d1_req_ready;
  logic [15:0] d1_req_data = 16'h0000;
  logic [4:0]  d1_req_len = 5'd0;
  logic        d1_resp_valid;
  logic        d1_resp_ready = 1'b0;
  logic [15:0] d1_resp_data;
  logic        d1_sck, d1_ss, d1_mosi;

  int n_checks = 0;
  int n_fails = 0;

  // Slave model: 0 = loopback, 1 = bit-reversal slave, 2 = word-driven slave
  int          slave_mode = 0;
  int          slave_len = 16;
  logic [15:0] slave_word = 16'h0000;
  logic        slave_miso = 1'b0;
  int          s_cnt = 0;
  logic [7:0]  s_byte = 8'h00;
  int          sck_rises = 0;
  int          ss_viol = 0;
  logic [15:0] mosi_cap = 16'h0000;
  int          d1_sck_rises = 0;

  assign miso = (slave_mode == 0) ? mosi : slave_miso;

  spi_master #(.DIV(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_len(req_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  spi_master #(.DIV(1)) dut_d1 (
    .clock(clock), .reset(reset),
    .req_valid(d1_req_valid), .req_ready(d1_req_ready), .req_data(d1_req_data), .req_len(d1_req_len),
    .resp_valid(d1_resp_valid), .resp_ready(d1_resp_ready), .resp_data(d1_resp_data),
    .sck(d1_sck), .ss(d1_ss), .mosi(d1_mosi), .miso(d1_mosi)
  );

  always #5 clock = ~clock;

  always @(negedge ss) begin
    s_cnt = 0;
    s_byte = 8'h00;
    slave_miso = (slave_mode == 2) ? slave_word[slave_len-1] : 1'b0;
  end

  always @(posedge sck) begin
    sck_rises++;
    if (ss) ss_viol++;
    mosi_cap = {mosi_cap[14:0], mosi};
    if (slave_mode == 1 && s_cnt < 8) s_byte = {s_byte[6:0], mosi};
    s_cnt++;
    if (slave_mode == 1)
      slave_miso = (s_cnt >= 8 && s_cnt < 16) ? s_byte[s_cnt-8] : 1'b0;
    else if (slave_mode == 2)
      slave_miso = (s_cnt < slave_len) ? slave_word[slave_len-1-s_cnt] : 1'b0;
  end

  always @(posedge d1_sck) d1_sck_rises++;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  len;
    int          mode;
    logic [15:0] exp_resp;
    int          exp_cycle;
  } vec_t;

  vec_t vecs[7];

  function automatic int eff(input logic [4:0] l);
    return (l == 5'd0 || l > 5'd16) ? 16 : int'(l);
  endfunction

  function automatic logic [15:0] mask_of(input int e);
    logic [16:0] m;
    m = (17'd1 << e) - 17'd1;
    return m[15:0];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request and waits (bounded) for the response; cycle counts
  // from 1 = first cycle after the accept edge.
  task automatic apply_stimulus(input logic [15:0] data, input logic [4:0] len, input bit consume,
                                output logic [15:0] resp, output int cycle, output bit ss_ok);
    @(negedge clock);
    check_output("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_data = data;
    req_len = len;
    sck_rises = 0;
    mosi_cap = 16'h0000;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_data = 16'($urandom);
    req_len = 5'($urandom);
    cycle = 1;
    ss_ok = 1'b1;
    while (!resp_valid && cycle < 400) begin
      if (ss !== 1'b0) ss_ok = 1'b0;
      @(negedge clock);
      cycle++;
    end
    if (!resp_valid) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL resp_timeout: got no response expected resp_valid within 400 cycles");
    end
    resp = resp_data;
    if (consume) begin
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      check_output("resp_cleared", 32'(resp_valid), 32'd0);
    end
  endtask

  task automatic run_checked(input logic [15:0] data, input logic [4:0] len, input logic [15:0] exp,
                             input int exp_cycle);
    logic [15:0] r;
    int          c;
    bit          ok;
    int          e;
    e = eff(len);
    slave_len = e;
    apply_stimulus(data, len, 1'b1, r, c, ok);
    check_output("resp_data", 32'(r), 32'(exp));
    check_output("latency", 32'(c), 32'(exp_cycle));
    check_output("sck_rises", 32'(sck_rises), 32'(e));
    check_output("ss_low", 32'(ok), 32'd1);
    check_output("mosi_bits", 32'(mosi_cap & mask_of(e)), 32'(data & mask_of(e)));
  endtask

  initial begin
    logic [15:0] r;
    int          c;
    bit          ok;
    int          bad;
    int          e;
    logic [15:0] d;
    logic [4:0]  l;

    vecs[0] = '{16'hA5C3, 5'd16, 0, 16'hA5C3, 67};
    vecs[1] = '{16'h2C00, 5'd16, 1, 16'h0034, 67};
    vecs[2] = '{16'h0001, 5'd1,  0, 16'h0001, 7};
    vecs[3] = '{16'h8001, 5'd0,  0, 16'h8001, 67};
    vecs[4] = '{16'h1234, 5'd20, 0, 16'h1234, 67};
    vecs[5] = '{16'hFFF9, 5'd4,  0, 16'h0009, 19};
    vecs[6] = '{16'h0155, 5'd9,  0, 16'h0155, 39};

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_output("rst_req_ready", 32'(req_ready), 32'd1);
    check_output("rst_ss", 32'(ss), 32'd1);
    check_output("rst_sck", 32'(sck), 32'd0);
    check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_output("rst_resp_data", 32'(resp_data), 32'd0);
    check_output("rst_mosi", 32'(mosi), 32'd0);

    for (int i = 0; i < 7; i++) begin
      slave_mode = vecs[i].mode;
      slave_word = 16'h0000;
      run_checked(vecs[i].data, vecs[i].len, vecs[i].exp_resp, vecs[i].exp_cycle);
    end

    slave_mode = 2;
    for (int i = 0; i < 24; i++) begin
      d = 16'($urandom);
      l = 5'($urandom_range(0, 31));
      slave_word = 16'($urandom);
      e = eff(l);
      run_checked(d, l, slave_word & mask_of(e), 1 + 2 + 4 * e);
    end

    // Response held under backpressure while a new request waits
    slave_mode = 0;
    slave_len = 12;
    apply_stimulus(16'h3C96, 5'd12, 1'b0, r, c, ok);
    check_output("bp_first", 32'(r), 32'h0C96);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_data = 16'h0003;
      req_len = 5'd2;
      @(negedge clock);
      if (resp_valid !== 1'b1 || resp_data !== 16'h0C96 || req_ready !== 1'b0 || ss !== 1'b1 || sck !== 1'b0)
        bad++;
    end
    check_output("bp_stable", 32'(bad), 32'd0);
    resp_ready = 1'b1;
    @(negedge clock);
    check_output("bp_idle_valid", 32'(resp_valid), 32'd0);
    check_output("bp_idle_ready", 32'(req_ready), 32'd1);
    slave_len = 2;
    sck_rises = 0;
    @(negedge clock);
    req_valid = 1'b0;
    check_output("bp_accept_ready", 32'(req_ready), 32'd0);
    check_output("bp_accept_ss", 32'(ss), 32'd0);
    c = 0;
    while (!resp_valid && c < 200) begin
      @(negedge clock);
      c++;
    end
    check_output("bp_second", 32'(resp_data), 32'h0003);
    check_output("bp_second_rises", 32'(sck_rises), 32'd2);
    @(negedge clock);
    resp_ready = 1'b0;
    check_output("bp_second_clear", 32'(resp_valid), 32'd0);

    // Reset in the middle of a transfer abandons it
    slave_mode = 0;
    req_valid = 1'b1;
    req_data = 16'hFFFF;
    req_len = 5'd16;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (20) @(negedge clock);
    check_output("mid_ss_low", 32'(ss), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_output("mid_rst_sck", 32'(sck), 32'd0);
    check_output("mid_rst_ss", 32'(ss), 32'd1);
    check_output("mid_rst_valid", 32'(resp_valid), 32'd0);
    check_output("mid_rst_ready", 32'(req_ready), 32'd1);
    sck_rises = 0;
    bad = 0;
    repeat (100) begin
      @(negedge clock);
      if (resp_valid !== 1'b0) bad++;
    end
    check_output("mid_no_resp", 32'(bad), 32'd0);
    check_output("mid_no_sck", 32'(sck_rises), 32'd0);

    // DIV=1 build in loopback
    @(negedge clock);
    d1_req_valid = 1'b1;
    d1_req_data = 16'h5A5A;
    d1_req_len = 5'd16;
    d1_sck_rises = 0;
    @(posedge clock);
    @(negedge clock);
    d1_req_valid = 1'b0;
    c = 1;
    bad = 0;
    while (!d1_resp_valid && c < 100) begin
      if (c >= 2 && d1_sck !== ((c % 2) == 0)) bad++;
      @(negedge clock);
      c++;
    end
    check_output("d1_latency", 32'(c), 32'd34);
    check_output("d1_resp", 32'(d1_resp_data), 32'h5A5A);
    check_output("d1_toggle", 32'(bad), 32'd0);
    check_output("d1_rises", 32'(d1_sck_rises), 32'd16);
    d1_resp_ready = 1'b1;
    @(negedge clock);
    d1_resp_ready = 1'b0;
    check_output("d1_clear", 32'(d1_resp_valid), 32'd0);

    check_output("sck_while_ss_high", 32'(ss_viol), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
    $finish;
  end

endmodule
